// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a FIFO read port one byte at a time and sends each
// byte as a UART frame.
// Frame format: start bit, 8 data bits sent LSB first, optional even parity,
// then STOP_BITS stop bits. Every bit lasts CLKS_PER_BIT clocks.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// after D7.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ivalid,
    input  logic [7:0] din,
    output logic       iready,
    output logic       txd,
    output logic       busy
);

    localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state_reg, state_next;
    logic [BW-1:0]   baud_reg, baud_next;
    logic [2:0]      idx_reg, idx_next;
    logic            stop_reg, stop_next;
    logic [7:0]      data_reg, data_next;
    logic            txd_reg, txd_next;
    logic            iready_reg, iready_next;
    logic            busy_reg, busy_next;
    logic            bit_end;

`ifdef UART_TX_PARITY_EN
    logic            parity_reg, parity_next;
    logic [8:0]      par_chain;

    // Even parity of the incoming byte, built as an XOR chain over din.
    assign par_chain[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_par
            assign par_chain[gi+1] = par_chain[gi] ^ din[gi];
        end
    endgenerate
`endif

    assign bit_end = (baud_reg == BAUD_LAST);

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            baud_reg   <= '0;
            idx_reg    <= '0;
            stop_reg   <= 1'b0;
            data_reg   <= '0;
            txd_reg    <= 1'b1;
            iready_reg <= 1'b0;
            busy_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            baud_reg   <= baud_next;
            idx_reg    <= idx_next;
            stop_reg   <= stop_next;
            data_reg   <= data_next;
            txd_reg    <= txd_next;
            iready_reg <= iready_next;
            busy_reg   <= busy_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    // Next-state logic: the line value for each bit is registered on the
    // edge that starts that bit, so txd changes exactly at bit boundaries.
    always_comb begin
        state_next  = state_reg;
        baud_next   = bit_end ? '0 : baud_reg + BW'(1);
        idx_next    = idx_reg;
        stop_next   = stop_reg;
        data_next   = data_reg;
        txd_next    = txd_reg;
        iready_next = iready_reg;
        busy_next   = busy_reg;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                baud_next   = '0;
                txd_next    = 1'b1;
                iready_next = 1'b1;
                busy_next   = 1'b0;
                if (ivalid && iready_reg) begin
                    state_next  = START;
                    data_next   = din;
                    txd_next    = 1'b0;
                    iready_next = 1'b0;
                    busy_next   = 1'b1;
                    idx_next    = '0;
                    stop_next   = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_next = par_chain[8];
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    txd_next   = data_reg[0];
                    data_next  = data_reg >> 1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        txd_next   = parity_reg;
`else
                        state_next = STOP;
                        txd_next   = 1'b1;
`endif
                        stop_next  = 1'b0;
                    end else begin
                        idx_next  = idx_reg + 3'd1;
                        txd_next  = data_reg[0];
                        data_next = data_reg >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                    txd_next   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (stop_reg == STOP_LAST) begin
                        state_next  = IDLE;
                        iready_next = 1'b1;
                        busy_next   = 1'b0;
                        txd_next    = 1'b1;
                    end else begin
                        stop_next = stop_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign iready = iready_reg;
    assign txd    = txd_reg;
    assign busy   = busy_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx: two instances (N=4 with 1 and 2 stop bits),
// expected line/status values queued per cycle when a byte is handed over.
module tb_fifo_uart_tx;

    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    typedef struct packed {
        logic txd;
        logic busy;
        logic iready;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] ivalid;
    logic [7:0] din [2];
    logic [1:0] iready;
    logic [1:0] txd;
    logic [1:0] busy;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   hs_q0[$];
    int   hs_q1[$];
    exp_t exp_q[$];

    fifo_uart_tx #(.CLKS_PER_BIT(N), .STOP_BITS(1)) u_dut_s1 (
        .clk(clk), .rst(rst), .ivalid(ivalid[0]), .din(din[0]),
        .iready(iready[0]), .txd(txd[0]), .busy(busy[0])
    );

    fifo_uart_tx #(.CLKS_PER_BIT(N), .STOP_BITS(2)) u_dut_s2 (
        .clk(clk), .rst(rst), .ivalid(ivalid[1]), .din(din[1]),
        .iready(iready[1]), .txd(txd[1]), .busy(busy[1])
    );

    always #5 clk = ~clk;

    // Handshake log: cycle number of every accepted byte per instance.
    always @(posedge clk) begin
        if (rst && ivalid[0] && iready[0]) hs_q0.push_back(cyc);
        if (rst && ivalid[1] && iready[1]) hs_q1.push_back(cyc);
        cyc++;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_bit(input logic b, input int cycles);
        exp_t e;
        e.txd    = b;
        e.busy   = 1'b1;
        e.iready = 1'b0;
        for (int i = 0; i < cycles; i++) exp_q.push_back(e);
    endtask

    task automatic push_idle();
        exp_t e;
        e.txd    = 1'b1;
        e.busy   = 1'b0;
        e.iready = 1'b1;
        exp_q.push_back(e);
    endtask

    // Reference frame: start, data LSB first, optional even parity, stops.
    task automatic push_frame(input logic [7:0] b, input int s);
        logic par;
        par = 1'b0;
        push_bit(1'b0, N);
        for (int k = 0; k < 8; k++) begin
            push_bit(b[k], N);
            par = par ^ b[k];
        end
        if (P == 1) push_bit(par, N);
        push_bit(1'b1, s * N);
    endtask

    // Present a byte at a falling edge; the next rising edge is the handshake.
    task automatic start_frame(input int d, input logic [7:0] b);
        @(negedge clk);
        ivalid[d] = 1'b1;
        din[d]    = b;
        chk($sformatf("iready_before_hs_%0d", d), {7'd0, iready[d]}, 8'd1);
        @(posedge clk);
    endtask

    // Compare one queued entry per cycle; ivalid drops at drop_idx and din
    // is scrambled from then on to show the frame in flight ignores it.
    task automatic run_frame(input int d, input int ncyc, input int drop_idx,
                             input logic [7:0] next_b);
        exp_t e;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            tests++;
            assert (exp_q.size() > 0) else begin
                fails++;
                $error("FAIL queue_underflow: observed empty expected entry at cycle %0d", i);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("txd_%0d_c%0d", d, i), {7'd0, txd[d]}, {7'd0, e.txd});
                chk($sformatf("busy_%0d_c%0d", d, i), {7'd0, busy[d]}, {7'd0, e.busy});
                chk($sformatf("iready_%0d_c%0d", d, i), {7'd0, iready[d]}, {7'd0, e.iready});
            end
            if (i == drop_idx) ivalid[d] = 1'b0;
            if (i >= drop_idx) din[d] = 8'($urandom);
            else               din[d] = next_b;
        end
    endtask

    initial begin
        int s1_bits;
        int s2_bits;
        int n0;
        s1_bits = 9 + P + 1;
        s2_bits = 9 + P + 2;
        ivalid  = 2'b00;
        din[0]  = 8'h00;
        din[1]  = 8'h00;

        // Reset held: idle-high line, not ready, not busy.
        repeat (3) @(negedge clk);
        chk("rst_txd",    {6'd0, txd},    8'h03);
        chk("rst_iready", {6'd0, iready}, 8'h00);
        chk("rst_busy",   {6'd0, busy},   8'h00);
        rst = 1'b1;
        #1;
        chk("iready_before_first_edge", {6'd0, iready}, 8'h00);
        @(negedge clk);
        chk("iready_after_first_edge", {6'd0, iready}, 8'h03);
        $display("[TB] reset release: iready=%b txd=%b busy=%b", iready, txd, busy);

        // Idle with ivalid low stays quiet.
        repeat (3) @(negedge clk);
        chk("idle_txd",  {6'd0, txd},  8'h03);
        chk("idle_busy", {6'd0, busy}, 8'h00);

        // Single byte 0xA5.
        start_frame(0, 8'hA5);
        push_frame(8'hA5, 1);
        push_idle();
        run_frame(0, s1_bits * N + 1, 0, 8'h00);
        chk_int("hs_count_a5", hs_q0.size(), 1);
        $display("[TB] frame 0xA5 done, %0d checks so far", tests);

        // Byte 0x07 (exercises the parity bit when enabled).
        start_frame(0, 8'h07);
        push_frame(8'h07, 1);
        push_idle();
        run_frame(0, s1_bits * N + 1, 0, 8'h00);
        $display("[TB] frame 0x07 done, %0d checks so far", tests);

        // Back-to-back 0x00 then 0xFF with ivalid held high.
        n0 = hs_q0.size();
        start_frame(0, 8'h00);
        push_frame(8'h00, 1);
        push_idle();
        push_frame(8'hFF, 1);
        push_idle();
        run_frame(0, 2 * (s1_bits * N + 1), s1_bits * N + 1, 8'hFF);
        chk_int("b2b_hs_count", hs_q0.size() - n0, 2);
        if (hs_q0.size() >= 2)
            chk_int("b2b_hs_spacing", hs_q0[hs_q0.size()-1] - hs_q0[hs_q0.size()-2],
                    s1_bits * N + 1);
        $display("[TB] back-to-back 0x00/0xFF done, %0d checks so far", tests);

        // Reset pulsed during DATA at E+13.
        start_frame(0, 8'hC3);
        push_frame(8'hC3, 1);
        run_frame(0, 13, 0, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst_txd",    {7'd0, txd[0]},    8'd1);
        chk("midrst_iready", {7'd0, iready[0]}, 8'd0);
        chk("midrst_busy",   {7'd0, busy[0]},   8'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("postrst_iready", {7'd0, iready[0]}, 8'd0);
        start_frame(0, 8'h3C);
        push_frame(8'h3C, 1);
        push_idle();
        run_frame(0, s1_bits * N + 1, 0, 8'h00);
        $display("[TB] reset mid-frame then 0x3C done, %0d checks so far", tests);

        // Two stop bits, byte 0x81, din scrambled mid-frame.
        start_frame(1, 8'h81);
        push_frame(8'h81, 2);
        push_idle();
        run_frame(1, s2_bits * N + 1, 0, 8'h00);
        chk_int("s2_hs_count", hs_q1.size(), 1);
        $display("[TB] two-stop frame 0x81 done, %0d checks so far", tests);

        chk_int("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
